// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller.
// Master is the datapath (drives hazard inputs); slave is the controller (drives enables).
// Counter width follows CNT_W so it must match the controller instance it connects to.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      id_instr;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             imem_ready;
  logic             dmem_busy;
  logic             perf_clr;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_instr, ex_memread, ex_rd, ex_redirect, imem_ready, dmem_busy, perf_clr,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, stall_cycles, flush_count
  );

  modport slave (
    input  id_instr, ex_memread, ex_rd, ex_redirect, imem_ready, dmem_busy, perf_clr,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Sequencing controller for PC / IF-ID: load-use bubbles, redirect flush, dmem hold, fetch wait.
// Latency: control outputs are combinational from state + inputs; counters update next edge.
// Backpressure: dmem_busy freezes the back end and the stall counter down-count; no flushes while held.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_ctrl_if.slave ctrl
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  // Bubbles still owed after the first one, which is issued from RUN.
  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_flush;
  logic pipe_hold;
  logic flush_evt;

  // rd, funct3 and funct7/immediate-high fields play no part in hazard detection.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{ctrl.id_instr[31:25], ctrl.id_instr[14:7]};

  assign opcode = ctrl.id_instr[6:0];
  assign rs1    = ctrl.id_instr[19:15];
  assign rs2    = ctrl.id_instr[24:20];

  // Source-register usage by opcode: U-type and JAL read no rs1; only R/R-W/S/B read rs2.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      OP_R, OP_RW, OP_S, OP_B:  uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  // x0 is never a real dependency, so a load targeting x0 cannot cause a stall.
  assign hazard = ctrl.ex_memread && (ctrl.ex_rd != 5'd0) &&
                  ((uses_rs1 && (ctrl.ex_rd == rs1)) || (uses_rs2 && (ctrl.ex_rd == rs2)));

  // Priority decode of pipeline controls and next FSM state; reset forces the safe flush pattern.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    flush_evt  = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (ctrl.ex_redirect) begin
      // The ID instruction is killed, so any pending or new load-use stall is moot.
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
      state_d    = RUN;
      cnt_d      = 3'd0;
    end else if (ctrl.dmem_busy) begin
      // Back end frozen: no bubble inserted, stall countdown paused.
      pipe_hold = 1'b1;
    end else if (state_q == LU_STALL) begin
      // Hazard is not re-evaluated here; the same ID instruction is already waiting.
      idex_flush = 1'b1;
      cnt_d      = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (hazard) begin
      idex_flush = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = LU_STALL;
        cnt_d   = CNT_INIT;
      end
    end else if (!ctrl.imem_ready) begin
      // Fetch not back yet: hold PC, let a NOP into IF/ID so ID does not re-issue.
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_hold  = 1'b0;
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (ctrl.perf_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_write && (stall_q != '1)) begin
        stall_d = stall_q + CNT_W'(1);
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_d = flush_q + CNT_W'(1);
      end
    end
  end

  // State, stall countdown and counters; asynchronous reset returns to RUN with everything cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ctrl.pc_write     = pc_write;
  assign ctrl.ifid_write   = ifid_write;
  assign ctrl.ifid_flush   = ifid_flush;
  assign ctrl.idex_flush   = idex_flush;
  assign ctrl.pipe_hold    = pipe_hold;
  assign ctrl.stall_cycles = stall_q;
  assign ctrl.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (1 bubble/32b, 3 bubbles/32b, 1 bubble/4b counters)
// driven by one directed stimulus stream, checked every cycle against a rule-level model,
// plus literal expectations at key points of each scenario.
module tb_hazard_stall_ctrl;

  localparam logic [31:0] I_NOP      = 32'h00000013;
  localparam logic [31:0] I_ADD      = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] I_LUI      = 32'h000052B7; // lui  x5,5
  localparam logic [31:0] I_ADDI_RS2 = 32'h00538313; // addi x6,x7,5  (rs2 field = 5)
  localparam logic [31:0] I_ADDI_X0  = 32'h00100293; // addi x5,x0,1

  // Control vector layout: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  localparam logic [4:0] C_RST   = 5'b00110;
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_BUB   = 5'b00010;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_REDIR = 5'b11110;
  localparam logic [4:0] C_FWAIT = 5'b01100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        imem_ready;
  logic        dmem_busy;
  logic        perf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(32)) bus0 ();
  hazard_stall_ctrl_if #(.CNT_W(32)) bus1 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  bus2 ();

  assign bus0.id_instr = id_instr;  assign bus0.ex_memread = ex_memread; assign bus0.ex_rd = ex_rd;
  assign bus0.ex_redirect = ex_redirect; assign bus0.imem_ready = imem_ready;
  assign bus0.dmem_busy = dmem_busy; assign bus0.perf_clr = perf_clr;
  assign bus1.id_instr = id_instr;  assign bus1.ex_memread = ex_memread; assign bus1.ex_rd = ex_rd;
  assign bus1.ex_redirect = ex_redirect; assign bus1.imem_ready = imem_ready;
  assign bus1.dmem_busy = dmem_busy; assign bus1.perf_clr = perf_clr;
  assign bus2.id_instr = id_instr;  assign bus2.ex_memread = ex_memread; assign bus2.ex_rd = ex_rd;
  assign bus2.ex_redirect = ex_redirect; assign bus2.imem_ready = imem_ready;
  assign bus2.dmem_busy = dmem_busy; assign bus2.perf_clr = perf_clr;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .ctrl(bus0));
  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .ctrl(bus1));
  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .ctrl(bus2));

  logic [4:0]  ctl [3];
  logic [63:0] stc [3];
  logic [63:0] flc [3];
  assign ctl[0] = {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush, bus0.idex_flush, bus0.pipe_hold};
  assign ctl[1] = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_flush, bus1.pipe_hold};
  assign ctl[2] = {bus2.pc_write, bus2.ifid_write, bus2.ifid_flush, bus2.idex_flush, bus2.pipe_hold};
  assign stc[0] = 64'(bus0.stall_cycles);
  assign stc[1] = 64'(bus1.stall_cycles);
  assign stc[2] = 64'(bus2.stall_cycles);
  assign flc[0] = 64'(bus0.flush_count);
  assign flc[1] = 64'(bus1.flush_count);
  assign flc[2] = 64'(bus2.flush_count);

  // ---------------- model ----------------
  int          lsc  [3] = '{1, 3, 1};
  logic [63:0] cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
  int          owed [3];   // bubbles still owed for the current load-use stall
  logic [63:0] m_sc [3];
  logic [63:0] m_fc [3];

  function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] op;
    logic       r1, r2;
    op = ins[6:0];
    r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    r2 =  (op == 7'h33 || op == 7'h3B || op == 7'h23 || op == 7'h63);
    return (r1 && ins[19:15] == r) || (r2 && ins[24:20] == r);
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic lit_ctl(input string nm, input int k, input logic [4:0] exp);
    chk(nm, k, 64'(ctl[k]), 64'(exp));
  endtask

  // Per-cycle compare against the model, sampled mid-cycle while inputs are stable.
  initial begin
    for (int k = 0; k < 3; k++) begin
      owed[k] = 0; m_sc[k] = '0; m_fc[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic [4:0]  e;
        logic [63:0] esc, efc;
        if (reset) begin
          e = C_RST; owed[k] = 0; m_sc[k] = '0; m_fc[k] = '0; esc = '0; efc = '0;
        end else begin
          esc = m_sc[k];
          efc = m_fc[k];
          if (ex_redirect) begin
            e = C_REDIR; owed[k] = 0;
          end else if (dmem_busy) begin
            e = C_HOLD;
          end else if (owed[k] > 0) begin
            e = C_BUB; owed[k] = owed[k] - 1;
          end else if (ex_memread && ex_rd != 5'd0 && reads_reg(id_instr, ex_rd)) begin
            e = C_BUB; owed[k] = lsc[k] - 1;
          end else if (!imem_ready) begin
            e = C_FWAIT;
          end else begin
            e = C_RUN;
          end
          if (perf_clr) begin
            m_sc[k] = '0; m_fc[k] = '0;
          end else begin
            if (!e[4] && m_sc[k] < cmax[k]) m_sc[k] = m_sc[k] + 1;
            if (ex_redirect && m_fc[k] < cmax[k]) m_fc[k] = m_fc[k] + 1;
          end
        end
        chk("pc_write",     k, 64'(ctl[k][4]), 64'(e[4]));
        chk("ifid_write",   k, 64'(ctl[k][3]), 64'(e[3]));
        chk("ifid_flush",   k, 64'(ctl[k][2]), 64'(e[2]));
        chk("idex_flush",   k, 64'(ctl[k][1]), 64'(e[1]));
        chk("pipe_hold",    k, 64'(ctl[k][0]), 64'(e[0]));
        chk("stall_cycles", k, stc[k], esc);
        chk("flush_count",  k, flc[k], efc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_instr = I_NOP; ex_memread = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [31:0] ins);
    ex_memread = 1'b1; ex_rd = rd; id_instr = ins;
  endtask

  task automatic clear_counters();
    idle(); perf_clr = 1'b1; tick(); perf_clr = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) tick();
    #1;
    lit_ctl("reset_ctl", 0, C_RST);
    chk("reset_stall", 0, stc[0], 64'd0);
    tick();
    reset = 1'b0;
    #1 lit_ctl("post_reset_run", 0, C_RUN);
    tick();

    // Load-use with one bubble (dut0)
    clear_counters();
    load_use(5'd5, I_ADD);
    #1 lit_ctl("lu1_bubble", 0, C_BUB);
    tick();
    ex_memread = 1'b0; ex_rd = 5'd0;
    #1 lit_ctl("lu1_resume", 0, C_RUN);
    chk("lu1_stall_cnt", 0, stc[0], 64'd1);
    tick();
    repeat (3) tick();

    // Load-use with three bubbles, dmem_busy inside the stall (dut1)
    clear_counters();
    load_use(5'd5, I_ADD);
    #1 lit_ctl("lu3_b1", 1, C_BUB);
    tick();
    idle(); dmem_busy = 1'b1;
    #1 lit_ctl("lu3_hold1", 1, C_HOLD);
    tick();
    #1 lit_ctl("lu3_hold2", 1, C_HOLD);
    tick();
    dmem_busy = 1'b0;
    #1 lit_ctl("lu3_b2", 1, C_BUB);
    tick();
    #1 lit_ctl("lu3_b3", 1, C_BUB);
    tick();
    #1 lit_ctl("lu3_resume", 1, C_RUN);
    chk("lu3_stall_cnt", 1, stc[1], 64'd5);
    tick();

    // No false hazards, then one true rs1 dependency as a positive control
    load_use(5'd0, I_ADDI_X0);
    #1 lit_ctl("nohz_rd0", 0, C_RUN);
    tick();
    load_use(5'd5, I_LUI);
    #1 lit_ctl("nohz_lui_rd5", 0, C_RUN);
    tick();
    load_use(5'd1, I_LUI);
    #1 lit_ctl("nohz_lui_rs1field", 1, C_RUN);
    tick();
    load_use(5'd5, I_ADDI_RS2);
    #1 lit_ctl("nohz_addi_rs2field", 0, C_RUN);
    tick();
    load_use(5'd7, I_ADDI_RS2);
    #1 lit_ctl("hz_addi_rs1", 0, C_BUB);
    tick();
    idle();
    repeat (3) tick();

    // Redirect beats hazard; redirect aborts an in-progress load-use stall
    clear_counters();
    load_use(5'd5, I_ADD); ex_redirect = 1'b1;
    #1 lit_ctl("redir_hz", 1, C_REDIR);
    tick();
    idle();
    #1 lit_ctl("redir_no_lustall", 1, C_RUN);
    chk("redir_flush_cnt", 1, flc[1], 64'd1);
    tick();
    load_use(5'd5, I_ADD);
    #1 lit_ctl("lu_enter", 1, C_BUB);
    tick();
    idle(); ex_redirect = 1'b1;
    #1 lit_ctl("redir_in_lustall", 1, C_REDIR);
    tick();
    idle();
    #1 lit_ctl("redir_back_run", 1, C_RUN);
    chk("redir_flush_cnt2", 1, flc[1], 64'd2);
    tick();

    // Fetch wait for four cycles, then clear racing an increment
    clear_counters();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 lit_ctl("fetch_wait", 0, C_FWAIT);
      tick();
    end
    imem_ready = 1'b1;
    #1 chk("fetch_stall_cnt", 0, stc[0], 64'd4);
    tick();
    perf_clr = 1'b1; imem_ready = 1'b0;
    tick();
    idle();
    #1 chk("clr_beats_inc", 0, stc[0], 64'd0);
    tick();

    // Saturation of the 4-bit counter under a long dmem_busy
    clear_counters();
    dmem_busy = 1'b1;
    repeat (20) tick();
    dmem_busy = 1'b0;
    #1 chk("sat_cnt4", 2, stc[2], 64'd15);
    chk("nosat_cnt32", 0, stc[0], 64'd20);
    tick();

    // Asynchronous reset in the middle of a load-use stall
    load_use(5'd5, I_ADD);
    tick();
    idle();
    #2 reset = 1'b1;
    #1 lit_ctl("async_rst_ctl", 1, C_RST);
    chk("async_rst_stall", 1, stc[1], 64'd0);
    tick();
    reset = 1'b0;
    #1 lit_ctl("after_rst_run", 1, C_RUN);
    tick();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
